// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side AXI4-Stream drain engine.
package fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fifo_tx_state_e;

    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned RD_LATENCY = 1;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register buffer; entry 0 is always the head, so head_data comes straight from a flop.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem0_q;
    logic [WIDTH-1:0] mem1_q;
    logic [1:0]       occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            occ_q  <= '0;
        end else if (clear) begin
            occ_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) mem0_q <= push_data;
                    else               mem1_q <= push_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    mem0_q <= mem1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy holds, the queue shifts by one.
                    if (occ_q == 2'd1) begin
                        mem0_q <= push_data;
                    end else begin
                        mem0_q <= mem1_q;
                        mem1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = mem0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_axis_tx.sv
// Drains a 1-cycle-latency FIFO read port into an AXI4-Stream master with fixed-length packet framing.
module fifo_axis_tx
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned CNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
    input  logic                  r_clk,
    input  logic                  rreset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  rd_enable,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BURST_LEN - 1);

    fifo_tx_state_e         state_q;
    fifo_tx_state_e         state_d;
    logic [RD_LATENCY-1:0]  inflight_q;
    logic [CNT_WIDTH-1:0]   beat_cnt_q;
    logic [1:0]             occ;
    logic [2:0]             level;
    logic                   accept;
    logic                   last_beat;
    logic                   buf_push;
    logic                   buf_clear;

    axis_skid_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (r_clk),
        .rst       (rreset),
        .clear     (buf_clear),
        .push      (buf_push),
        .push_data (fifo_read_data),
        .pop       (accept),
        .head_data (m_axis_tdata),
        .occ       (occ)
    );

    assign accept    = m_axis_tvalid && m_axis_tready;
    assign last_beat = (beat_cnt_q == LAST_IDX);
    assign level     = {1'b0, occ} + {2'b00, inflight_q[0]};

    always_ff @(posedge r_clk) begin
        if (rreset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush && inflight_q[0]) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        buf_clear     = flush;
        buf_push      = inflight_q[0] && (state_q == RUN);
        m_axis_tvalid = (occ != 2'd0);
        m_axis_tlast  = m_axis_tvalid && last_beat;
        busy          = (occ != 2'd0) || inflight_q[0] || (state_q == FLUSH);
        // A beat leaving this cycle frees its slot, which is what keeps 1 beat/cycle streaming.
        rd_enable     = (state_q == RUN) && !rreset && !fifo_empty && !flush
                        && (level < (3'(BUF_DEPTH) + {2'b00, accept}));
    end

    always_ff @(posedge r_clk) begin
        if (rreset) begin
            inflight_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            inflight_q <= RD_LATENCY'(rd_enable);
            if (flush)
                beat_cnt_q <= '0;
            else if (accept)
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Directed bench for fifo_axis_tx: FIFO model plus in-order scoreboard, and a BURST_LEN=1 instance.
module tb_fifo_axis_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned BL = 16;

    logic          r_clk = 1'b0;
    logic          rreset;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_read_data;
    logic          rd_enable;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;

    logic          b_flush;
    logic          b_empty;
    logic [DW-1:0] b_rdata;
    logic          b_rd;
    logic [DW-1:0] b_tdata;
    logic          b_valid;
    logic          b_ready;
    logic          b_last;
    logic          b_busy;

    always #5 r_clk = ~r_clk;

    fifo_axis_tx #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .r_clk          (r_clk),
        .rreset         (rreset),
        .flush          (flush),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .rd_enable      (rd_enable),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy)
    );

    fifo_axis_tx #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut_b1 (
        .r_clk          (r_clk),
        .rreset         (rreset),
        .flush          (b_flush),
        .fifo_empty     (b_empty),
        .fifo_read_data (b_rdata),
        .rd_enable      (b_rd),
        .m_axis_tdata   (b_tdata),
        .m_axis_tvalid  (b_valid),
        .m_axis_tready  (b_ready),
        .m_axis_tlast   (b_last),
        .busy           (b_busy)
    );

    logic [DW-1:0] fq[$];
    logic [DW:0]   exp_q[$];
    int unsigned   push_idx, checks, passed, cyc, acc_cnt, first_acc_cyc, last_acc_cyc;
    int unsigned   b_next, b_exp, b_beats, gaps, first_pop;
    logic          s_rd, s_valid, s_busy, s_last, s_b_rd;
    logic [DW-1:0] s_tdata, hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        logic lst;
        lst = ((push_idx % BL) == BL - 1);
        fq.push_back(d);
        exp_q.push_back({lst, d});
        push_idx++;
        fifo_empty = 1'b0;
    endtask

    // Words already popped are lost; whatever remains in the FIFO starts a fresh packet.
    task automatic resync();
        logic lst;
        exp_q.delete();
        push_idx = 0;
        foreach (fq[i]) begin
            lst = ((push_idx % BL) == BL - 1);
            exp_q.push_back({lst, fq[i]});
            push_idx++;
        end
    endtask

    task automatic tick();
        logic [DW:0] e;
        @(negedge r_clk);
        cyc++;
        s_rd    = rd_enable;
        s_valid = m_axis_tvalid;
        s_busy  = busy;
        s_tdata = m_axis_tdata;
        s_last  = m_axis_tlast;
        s_b_rd  = b_rd;
        if (s_rd === 1'b1) check("pop_nonempty", fq.size() != 0, 1);
        if (s_valid === 1'b1 && m_axis_tready === 1'b1 && rreset === 1'b0 && flush === 1'b0) begin
            if (acc_cnt == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            acc_cnt++;
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tdata", s_tdata, e[DW-1:0]);
                check("tlast", s_last, e[DW]);
            end
        end
        if (b_valid === 1'b1 && b_ready === 1'b1 && rreset === 1'b0) begin
            check("b1_tlast", b_last, 1);
            check("b1_tdata", b_tdata, DW'(b_exp));
            b_exp++;
            b_beats++;
        end
        @(posedge r_clk);
        #1;
        if (s_rd === 1'b1 && fq.size() != 0) fifo_read_data = fq.pop_front();
        else                                 fifo_read_data = 8'hEE;
        fifo_empty = (fq.size() == 0);
        if (rreset || flush) resync();
        if (s_b_rd === 1'b1) begin
            b_rdata = DW'(b_next);
            b_next++;
        end
        if (rreset) b_exp = b_next;
        b_ready = ~b_ready;
    endtask

    initial begin
        rreset = 1'b1; flush = 1'b0; fifo_empty = 1'b1; fifo_read_data = '0;
        m_axis_tready = 1'b1;
        b_flush = 1'b0; b_empty = 1'b0; b_rdata = '0; b_ready = 1'b1;
        push_idx = 0; checks = 0; passed = 0; cyc = 0; acc_cnt = 0;
        first_acc_cyc = 0; last_acc_cyc = 0; b_next = 0; b_exp = 0; b_beats = 0; gaps = 0;

        // Reset with a non-empty FIFO, then streaming of 0x00..0x1F
        for (int w = 0; w < 32; w++) push_word(DW'(w));
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i > 0) begin
                check("rst_rd_enable", s_rd, 0);
                check("rst_tvalid", s_valid, 0);
                check("rst_busy", s_busy, 0);
            end
        end
        check("rst_tdata", s_tdata, 0);
        check("rst_tlast", s_last, 0);
        check("rst_b1_busy", b_busy, 0);

        rreset = 1'b0;
        tick();
        check("first_pop", s_rd, 1);
        first_pop = cyc;
        for (int n = 0; n < 80 && acc_cnt < 32; n++) tick();
        check("t2_beats", acc_cnt, 32);
        check("t2_latency", first_acc_cyc - first_pop, 2);
        check("t2_back2back", last_acc_cyc - first_acc_cyc, 31);

        // Backpressure mid-stream
        for (int w = 0; w < 32; w++) push_word(DW'(8'h40 + w));
        repeat (5) tick();
        m_axis_tready = 1'b0;
        tick();
        hold = s_tdata;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t3_valid", s_valid, 1);
            check("t3_hold", s_tdata, hold);
            check("t3_no_pop", s_rd, 0);
        end
        m_axis_tready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        check("t3_drained", exp_q.size(), 0);

        // FIFO supplying one word every three cycles
        for (int w = 0; w < 20; w++) begin
            push_word(DW'(8'h60 + w));
            repeat (3) begin
                tick();
                if (s_valid === 1'b0) gaps++;
            end
        end
        repeat (4) tick();
        check("t4_drained", exp_q.size(), 0);
        check("t4_gaps", gaps > 0, 1);

        // Flush with one word buffered and one in flight
        m_axis_tready = 1'b0;
        for (int w = 0; w < 8; w++) push_word(DW'(8'hA0 + w));
        tick();
        tick();
        flush = 1'b1;
        tick();
        check("t5_pre_valid", s_valid, 1);
        check("t5_pre_busy", s_busy, 1);
        flush = 1'b0;
        tick();
        check("t5_flush_valid", s_valid, 0);
        check("t5_flush_busy", s_busy, 1);
        check("t5_flush_no_pop", s_rd, 0);
        tick();
        check("t5_run_pop", s_rd, 1);
        check("t5_run_busy", s_busy, 0);
        for (int w = 0; w < 16; w++) push_word(DW'(8'hB0 + w));
        m_axis_tready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        check("t5_drained", exp_q.size(), 0);

        // Reset in the middle of a packet
        for (int w = 0; w < 10; w++) push_word(DW'(8'hC0 + w));
        repeat (4) tick();
        rreset = 1'b1;
        tick();
        rreset = 1'b0;
        tick();
        check("t6_rst_valid", s_valid, 0);
        check("t6_rst_busy", s_busy, 0);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
        check("t6_drained", exp_q.size(), 0);

        check("b1_beats_seen", b_beats > 10, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
